// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers. All constant multiplies are built from
// xtime chains so they synthesise to plain XOR networks.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  col_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } imc_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    // x*8 is the common term of every InvMixColumns coefficient.
    function automatic logic [7:0] gf_mul8(input logic [7:0] b);
        return xtime(xtime(xtime(b)));
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        return gf_mul8(b) ^ b;
    endfunction

    function automatic logic [7:0] gf_mulb(input logic [7:0] b);
        return gf_mul8(b) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gf_muld(input logic [7:0] b);
        return gf_mul8(b) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gf_mule(input logic [7:0] b);
        return gf_mul8(b) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

endpackage

// File: rtl/inv_mix_single_column.sv
// Combinational InvMixColumns on one 32-bit column; byte s0 sits in [31:24].
module inv_mix_single_column
    import aes_pkg::*;
(
    input  logic [31:0] col,
    output logic [31:0] mixed
);

    logic [7:0] s0, s1, s2, s3;

    assign {s0, s1, s2, s3} = col;

    assign mixed[31:24] = gf_mule(s0) ^ gf_mulb(s1) ^ gf_muld(s2) ^ gf_mul9(s3);
    assign mixed[23:16] = gf_mul9(s0) ^ gf_mule(s1) ^ gf_mulb(s2) ^ gf_muld(s3);
    assign mixed[15:8]  = gf_muld(s0) ^ gf_mul9(s1) ^ gf_mule(s2) ^ gf_mulb(s3);
    assign mixed[7:0]   = gf_mulb(s0) ^ gf_muld(s1) ^ gf_mul9(s2) ^ gf_mule(s3);

endmodule

// File: rtl/inv_mix_columns.sv
// Column-serial AES InvMixColumns with valid/ready handshakes on both sides;
// COLS_PER_CYCLE columns of the working register are rewritten per clock.
module inv_mix_columns
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [127:0] state_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [127:0] state_o
);

    localparam int NUM_COLS = 4;

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("inv_mix_columns: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    imc_state_e       fsm_q;
    logic [1:0]       col_q;
    logic [0:3][31:0] work_q;
    logic [0:3][31:0] work_next;
    logic [31:0]      col_out [COLS_PER_CYCLE];
    logic             last_col;

    // Column index wraps modulo 4, so unreachable counter values stay in range.
    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
        logic [1:0] idx;
        assign idx = col_q + 2'(k);
        inv_mix_single_column u_col (
            .col   (work_q[idx]),
            .mixed (col_out[k])
        );
    end

    always_comb begin
        work_next = work_q;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            work_next[col_q + 2'(k)] = col_out[k];
        end
    end

    assign last_col = (int'(col_q) + COLS_PER_CYCLE) >= NUM_COLS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            col_q   <= '0;
            work_q  <= '0;
            valid_o <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (valid_i) begin
                        work_q <= state_i;
                        col_q  <= '0;
                        fsm_q  <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    work_q <= work_next;
                    col_q  <= col_q + 2'(COLS_PER_CYCLE);
                    if (last_col) begin
                        fsm_q   <= DONE;
                        valid_o <= 1'b1;
                    end
                end
                DONE: begin
                    // Output handshake; a waiting input block is taken in the same cycle.
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        if (valid_i) begin
                            work_q <= state_i;
                            col_q  <= '0;
                            fsm_q  <= COMPUTE;
                        end else begin
                            fsm_q <= IDLE;
                        end
                    end
                end
                default: begin
                    fsm_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_o = (fsm_q == IDLE) || ((fsm_q == DONE) && ready_i);
    assign state_o = work_q;

endmodule

// File: tb/tb_inv_mix_columns.sv
// Scoreboard bench for inv_mix_columns: a driver queues expected results from a
// byte-level GF(2^8) matrix model, a negedge monitor pops and compares them.
module tb_inv_mix_columns;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid_i = 1'b0;
    logic         ready_i = 1'b1;
    logic         ready_o;
    logic         valid_o;
    logic [127:0] state_i = '0;
    logic [127:0] state_o;

    always #5 clk = ~clk;

    inv_mix_columns #(.COLS_PER_CYCLE(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .state_i (state_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .state_o (state_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int aux_done = 0;
    logic [127:0] exp_q[$];

    localparam logic [127:0] FIPS_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] FIPS_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] VEC2_IN  = 128'hd5d5d7d6_4d7ebdf8_00000000_00000000;
    localparam logic [127:0] VEC2_OUT = 128'hd4d4d4d5_2d26314c_00000000_00000000;
    localparam logic [127:0] ONES     = 128'h01010101_01010101_01010101_01010101;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference model: polynomial multiply then reduce by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p ^= (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    // Circulant matrix product; coef holds the first matrix row.
    function automatic logic [127:0] mix_model(input logic [127:0] s, input logic [31:0] coef);
        logic [127:0] r;
        logic [7:0]   b [16];
        logic [7:0]   c [4];
        logic [7:0]   acc;
        r = '0;
        for (int i = 0; i < 16; i++) b[i] = s[127 - 8*i -: 8];
        for (int j = 0; j < 4; j++) c[j] = coef[31 - 8*j -: 8];
        for (int col = 0; col < 4; col++) begin
            for (int row = 0; row < 4; row++) begin
                acc = '0;
                for (int j = 0; j < 4; j++) acc ^= gmul(c[(j - row + 4) % 4], b[4*col + j]);
                r[127 - 8*(4*col + row) -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        return mix_model(s, 32'h0e0b0d09);
    endfunction

    function automatic logic [127:0] fwd_mix(input logic [127:0] s);
        return mix_model(s, 32'h02030101);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called just after a rising edge; returns just after the accept edge.
    task automatic send(input logic [127:0] s, input logic [127:0] e);
        int w;
        w = 0;
        valid_i = 1'b1;
        state_i = s;
        @(negedge clk);
        while (!ready_o && w < 60) begin
            w++;
            @(negedge clk);
        end
        if (!ready_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: ready_o stuck low, expected 1");
            @(posedge clk);
            #1 valid_i = 1'b0;
            return;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        valid_i = 1'b0;
        state_i = rnd128();
    endtask

    // Monitor: output compare, hold-under-backpressure, latency and pulse checks.
    logic         pv = 1'b0;
    logic         pr = 1'b0;
    logic         ph = 1'b0;
    logic [127:0] ps = '0;

    always @(negedge clk) begin
        if (rst) begin
            pv <= 1'b0;
            ph <= 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("hold_valid", 128'(valid_o), 128'(1));
                chk("hold_state", state_o, ps);
            end
            if (ph) chk("valid_drop", 128'(valid_o), 128'(0));
            if (valid_o && !pv) chk("latency", 128'(cyc - acc_cyc), 128'(4));
            if (valid_o && !ready_i) chk("bp_ready_o", 128'(ready_o), 128'(0));
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: got %h with no block pending", state_o);
                end else begin
                    chk("result", state_o, exp_q.pop_front());
                end
            end
            pv <= valid_o;
            pr <= ready_i;
            ps <= state_o;
            ph <= valid_o && ready_i;
        end
    end

    // Wider instances: latency 4/C and the directed vectors.
    for (genvar g = 0; g < 2; g++) begin : g_aux
        localparam int C = (g == 0) ? 2 : 4;
        logic         a_rst;
        logic         a_vi;
        logic         a_ro;
        logic         a_vo;
        logic         a_ri;
        logic [127:0] a_si;
        logic [127:0] a_so;

        inv_mix_columns #(.COLS_PER_CYCLE(C)) u_aux (
            .clk     (clk),
            .rst     (a_rst),
            .valid_i (a_vi),
            .ready_o (a_ro),
            .state_i (a_si),
            .valid_o (a_vo),
            .ready_i (a_ri),
            .state_o (a_so)
        );

        initial begin
            logic [127:0] vin [3];
            logic [127:0] vout [3];
            int lat;
            vin[0] = VEC2_IN;  vout[0] = VEC2_OUT;
            vin[1] = FIPS_IN;  vout[1] = FIPS_OUT;
            vin[2] = rnd128(); vout[2] = inv_mix(vin[2]);
            a_rst = 1'b1; a_vi = 1'b0; a_ri = 1'b1; a_si = '0;
            repeat (3) @(posedge clk);
            #1 a_rst = 1'b0;
            for (int v = 0; v < 3; v++) begin
                chk($sformatf("aux%0d_ready", C), 128'(a_ro), 128'(1));
                a_vi = 1'b1;
                a_si = vin[v];
                @(posedge clk);
                #1 a_vi = 1'b0;
                a_si = '0;
                lat = 0;
                while (!a_vo && lat < 10) begin
                    @(posedge clk);
                    #1 lat++;
                end
                chk($sformatf("aux%0d_latency", C), 128'(lat), 128'(4 / C));
                chk($sformatf("aux%0d_result", C), a_so, vout[v]);
                @(posedge clk);
                #1 chk($sformatf("aux%0d_drop", C), 128'(a_vo), 128'(0));
            end
            aux_done++;
        end
    end

    initial begin
        logic [127:0] x;
        logic [127:0] y;
        int w;

        // Reset state, during and after reset.
        @(negedge clk);
        chk("rst_ready_o", 128'(ready_o), 128'(1));
        chk("rst_valid_o", 128'(valid_o), 128'(0));
        chk("rst_state_o", state_o, 128'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_ready_o", 128'(ready_o), 128'(1));
        chk("idle_valid_o", 128'(valid_o), 128'(0));
        @(posedge clk);
        #1;

        // Directed vectors with constant expectations.
        send(FIPS_IN, FIPS_OUT);
        repeat (6) @(posedge clk);
        #1;
        send(VEC2_IN, VEC2_OUT);
        send(128'h0, 128'h0);
        send(ONES, ONES);
        repeat (6) @(posedge clk);
        #1;

        // Backpressure: hold the result, then accept a new block on the releasing cycle.
        ready_i = 1'b0;
        x = rnd128();
        send(x, inv_mix(x));
        w = 0;
        while (!valid_o && w < 20) begin
            w++;
            @(negedge clk);
        end
        chk("bp_valid_rise", 128'(valid_o), 128'(1));
        repeat (5) @(posedge clk);
        #1;
        y = rnd128();
        fork
            send(y, inv_mix(y));
            begin
                repeat (2) @(posedge clk);
                #1 ready_i = 1'b1;
            end
        join
        chk("bp_accept_same_cycle", 128'(cyc - acc_cyc), 128'(0));

        // Streaming under continuous ready_i.
        for (int i = 0; i < 9; i++) begin
            x = rnd128();
            send(x, inv_mix(x));
        end

        // Round trip through the forward transform.
        for (int i = 0; i < 4; i++) begin
            x = rnd128();
            send(fwd_mix(x), x);
        end

        // Streaming with random backpressure.
        fork
            begin
                repeat (60) begin
                    @(posedge clk);
                    #1 ready_i = 1'($urandom_range(0, 1));
                end
                ready_i = 1'b1;
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    x = rnd128();
                    send(x, inv_mix(x));
                end
            end
        join
        repeat (8) @(posedge clk);
        #1 ready_i = 1'b1;

        // Reset in the middle of COMPUTE, at column 2.
        x = rnd128();
        send(x, inv_mix(x));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        void'(exp_q.pop_back());
        #1;
        chk("abort_valid_o", 128'(valid_o), 128'(0));
        chk("abort_state_o", state_o, 128'h0);
        chk("abort_ready_o", 128'(ready_o), 128'(1));
        @(posedge clk);
        #1 rst = 1'b0;
        x = rnd128();
        send(x, inv_mix(x));

        // Drain the scoreboard and wait for the wider instances.
        w = 0;
        while ((exp_q.size() != 0 || aux_done < 2) && w < 200) begin
            w++;
            @(negedge clk);
        end
        chk("drain", 128'(exp_q.size()), 128'(0));
        chk("aux_done", 128'(aux_done), 128'(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
